// File: rtl/alu_op_sequencer.sv
// Issues one ALU operation at a time: registers operands/ALUCtrl, holds them for an
// op-dependent latency, captures the ALU result and returns it over a valid/ready port.
module alu_op_sequencer #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_op,
  input  logic [63:0]        req_a,
  input  logic [63:0]        req_b,
  input  logic               req_cin,
  input  logic [TAG_W-1:0]   req_tag,
  output logic [63:0]        alu_a,
  output logic [63:0]        alu_b,
  output logic               alu_cin,
  output logic [3:0]         alu_ctrl,
  input  logic [127:0]       alu_result,
  input  logic               alu_zero,
  input  logic               alu_overflow,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [127:0]       rsp_result,
  output logic               rsp_zero,
  output logic               rsp_overflow,
  output logic               rsp_err,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_DIV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, lat_m1;
  logic               op_known, op_err, err_q;
  logic [TAG_W-1:0]   tag_q;
  logic               accept, capture;

  // Latency decode; errored ops finish in a single cycle regardless of code
  always_comb begin
    op_known = 1'b1;
    lat_m1   = '0;
    case (req_op)
      OP_ADD, OP_SUB, OP_SLT, OP_AND: op_known = 1'b1;
      OP_MUL:  lat_m1 = CNT_W'(MUL_LAT - 1);
      OP_DIV:  lat_m1 = CNT_W'(DIV_LAT - 1);
      default: op_known = 1'b0;
    endcase
    op_err = !op_known || (req_op == OP_DIV && req_b == '0);
    if (op_err) lat_m1 = '0;
  end

  assign req_ready = !flush && (state == IDLE || (state == DONE && rsp_ready));
  assign accept    = req_valid && req_ready;
  assign capture   = !flush && state == EXEC && cnt == '0;
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    if (accept) state_nx = EXEC;
        EXEC:    if (cnt == '0) state_nx = DONE;
        DONE:    if (rsp_ready) state_nx = accept ? EXEC : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      err_q        <= 1'b0;
      tag_q        <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_cin      <= 1'b0;
      alu_ctrl     <= OP_AND;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_tag      <= '0;
    end else begin
      if (accept) begin
        alu_a    <= req_a;
        alu_b    <= req_b;
        alu_cin  <= req_cin;
        alu_ctrl <= req_op;
        tag_q    <= req_tag;
        err_q    <= op_err;
        cnt      <= lat_m1;
      end else if (!flush && state == EXEC && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      // Overflow is only meaningful from the adder/subtractor
      if (capture) begin
        rsp_result   <= err_q ? '0 : alu_result;
        rsp_zero     <= err_q ? 1'b1 : alu_zero;
        rsp_overflow <= !err_q && (alu_ctrl == OP_ADD || alu_ctrl == OP_SUB) && alu_overflow;
        rsp_err      <= err_q;
        rsp_tag      <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed plus randomized checks of alu_op_sequencer against a behavioural ALU
// and an expected-response model derived from the op latency/error rules.
module tb_alu_op_sequencer;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;
  localparam int TAG_W   = 4;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_DIV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [3:0]         req_op = '0;
  logic [63:0]        req_a = '0;
  logic [63:0]        req_b = '0;
  logic               req_cin = 1'b0;
  logic [TAG_W-1:0]   req_tag = '0;
  logic [63:0]        alu_a, alu_b;
  logic               alu_cin;
  logic [3:0]         alu_ctrl;
  logic [127:0]       alu_result;
  logic               alu_zero, alu_overflow;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [127:0]       rsp_result;
  logic               rsp_zero, rsp_overflow, rsp_err;
  logic [TAG_W-1:0]   rsp_tag;
  logic               busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural 64-bit ALU; garbage for undefined cases so masking is observable
  function automatic logic [127:0] alu_fn(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input logic cin);
    logic signed [63:0]  sa, sb;
    logic signed [127:0] pa, pb;
    logic [63:0]         s;
    sa = a; sb = b; pa = sa; pb = sb; s = '0;
    alu_fn = '0;
    case (op)
      OP_ADD: begin s = a + b + 64'(cin); alu_fn = {{64{s[63]}}, s}; end
      OP_SUB: begin s = a - b; alu_fn = {{64{s[63]}}, s}; end
      OP_MUL: alu_fn = pa * pb;
      OP_DIV: begin
        if (b == '0) alu_fn = {2{64'hDEAD_BEEF_0BAD_F00D}};
        else begin s = sa / sb; alu_fn = {{64{s[63]}}, s}; end
      end
      OP_SLT: alu_fn = {127'd0, sa < sb};
      OP_AND: alu_fn = {64'd0, a & b};
      default: alu_fn = {2{64'hA5A5_5A5A_0F0F_F0F0}};
    endcase
  endfunction

  function automatic logic ovf_fn(input logic [3:0] op, input logic [63:0] a,
                                  input logic [63:0] b, input logic cin);
    logic [63:0] s;
    if (op == OP_ADD) begin
      s = a + b + 64'(cin);
      ovf_fn = (a[63] == b[63]) && (s[63] != a[63]);
    end else if (op == OP_SUB) begin
      s = a - b;
      ovf_fn = (a[63] != b[63]) && (s[63] != a[63]);
    end else begin
      ovf_fn = 1'b1;
    end
  endfunction

  assign alu_result   = alu_fn(alu_ctrl, alu_a, alu_b, alu_cin);
  assign alu_zero     = (alu_result == '0);
  assign alu_overflow = ovf_fn(alu_ctrl, alu_a, alu_b, alu_cin);

  alu_op_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err),
    .rsp_tag(rsp_tag), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_state(input string tag);
    chk({tag, "_alu"}, {alu_a, alu_b}, '0);
    chk({tag, "_rsp"}, rsp_result, '0);
    chk({tag, "_ctl"}, {alu_ctrl, alu_cin, rsp_tag, rsp_err, rsp_zero, rsp_overflow,
                        rsp_valid, busy, req_ready}, 128'd1);
  endtask

  // Issue one op from IDLE (or from a stalled DONE), check latency, hold and response.
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic [TAG_W-1:0] tag, input int stall,
                        input bit hold, output logic [127:0] o_res,
                        output logic [TAG_W-1:0] o_tag, output logic o_err, output logic o_zero);
    logic         e_err, e_zero, e_ovf;
    logic [127:0] e_res;
    int           lat, n;
    bit           ok;
    e_err  = !(op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SLT, OP_AND}) ||
             (op == OP_DIV && b == '0);
    lat    = e_err ? 1 : (op == OP_MUL) ? MUL_LAT : (op == OP_DIV) ? DIV_LAT : 1;
    e_res  = e_err ? '0 : alu_fn(op, a, b, cin);
    e_zero = e_err ? 1'b1 : (alu_fn(op, a, b, cin) == '0);
    e_ovf  = (!e_err && (op == OP_ADD || op == OP_SUB)) ? ovf_fn(op, a, b, cin) : 1'b0;

    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cin = cin; req_tag = tag;
    rsp_ready = (stall == 0);
    #1;
    chk("accept_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    req_op = 4'($urandom); req_tag = TAG_W'($urandom); req_cin = 1'($urandom);
    n = 0; ok = 1;
    while (!rsp_valid && n < 40) begin
      if (!(alu_a === a && alu_b === b && alu_ctrl === op && alu_cin === cin &&
            busy === 1'b1 && req_ready === 1'b0)) ok = 0;
      req_valid = 1'($urandom);
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    chk("latency", n, lat);
    chk("exec_hold", ok, 1);
    o_res = rsp_result; o_tag = rsp_tag; o_err = rsp_err; o_zero = rsp_zero;
    chk("result", rsp_result, e_res);
    chk("zero", rsp_zero, e_zero);
    chk("overflow", rsp_overflow, e_ovf);
    chk("err", rsp_err, e_err);
    chk("tag", rsp_tag, tag);
    ok = 1;
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'($urandom);
      @(negedge clk);
      if (!(rsp_valid === 1'b1 && req_ready === 1'b0 && rsp_result === e_res &&
            rsp_tag === tag && rsp_err === e_err && rsp_zero === e_zero &&
            rsp_overflow === e_ovf)) ok = 0;
    end
    req_valid = 1'b0;
    if (stall > 0) chk("stall_hold", ok, 1);
    if (!hold) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("retire", {rsp_valid, busy}, 0);
    end
  endtask

  initial begin
    logic [127:0]     res;
    logic [TAG_W-1:0] tg;
    logic             er, zr;
    logic [3:0]       op;
    logic [63:0]      ra, rb;
    bit               ok;
    int               acc;

    @(negedge clk);
    chk_zero_state("reset");
    rst_n = 1'b1;

    // Async reset in the middle of a MUL
    req_valid = 1'b1; req_op = OP_MUL; req_a = -64'sd3; req_b = 64'sd4; req_tag = 4'd2;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero_state("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_ready", req_ready, 1);
    ok = 1;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) ok = 0;
    end
    chk("rst_noresp", ok, 1);

    run_op(OP_ADD, 64'd5, 64'd7, 1'b1, 4'd3, 0, 0, res, tg, er, zr);
    chk("add_13", res, 128'd13);
    chk("add_tag", tg, 4'd3);
    chk("add_zero", zr, 0);
    chk("add_err", er, 0);

    run_op(OP_MUL, -64'sd3, 64'sd4, 1'b0, 4'd1, 0, 0, res, tg, er, zr);
    chk("mul_m12", res, -128'sd12);

    run_op(OP_DIV, 64'd100, 64'd0, 1'b0, 4'd4, 0, 0, res, tg, er, zr);
    chk("div0_res", res, 0);
    chk("div0_err", er, 1);
    chk("div0_zero", zr, 1);
    run_op(OP_DIV, 64'd100, 64'd7, 1'b0, 4'd5, 0, 0, res, tg, er, zr);
    chk("div_14", res, 128'd14);

    // Back-to-back ADDs with the consumer always ready
    req_valid = 1'b1; req_op = OP_ADD; req_a = 64'd1; req_b = 64'd1; rsp_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      #1 if (req_valid && req_ready) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_accepts", acc, 5);
    @(negedge clk);
    chk("b2b_idle", {busy, rsp_valid}, 0);

    // SUB stalled 5 cycles, then retire and accept on the same edge
    run_op(OP_SUB, 64'd50, 64'd8, 1'b0, 4'd7, 5, 1, res, tg, er, zr);
    chk("sub_42", res, 128'd42);
    chk("sub_pending", rsp_valid, 1);
    run_op(OP_ADD, 64'd1, 64'd2, 1'b0, 4'd9, 0, 0, res, tg, er, zr);
    chk("chain_3", res, 128'd3);

    // Flush two cycles into a DIV with a request waiting
    req_valid = 1'b1; req_op = OP_DIV; req_a = 64'd100; req_b = 64'd7; req_tag = 4'd5;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_op = OP_ADD; req_a = 64'd2; req_b = 64'd2; req_tag = 4'd6;
    #1 chk("fl_noaccept", req_ready, 0);
    @(negedge clk);
    chk("fl_idle", {rsp_valid, busy, req_ready}, 0);
    @(negedge clk);
    chk("fl_idle2", {rsp_valid, busy}, 0);
    flush = 1'b0;
    run_op(OP_ADD, 64'd2, 64'd2, 1'b0, 4'd6, 0, 0, res, tg, er, zr);
    chk("fl_next", res, 128'd4);
    chk("fl_next_tag", tg, 4'd6);
    ok = 1;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) ok = 0;
    end
    chk("fl_noresp", ok, 1);

    // Randomized ops including invalid codes and zero divisors
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0: op = OP_ADD;
        1: op = OP_SUB;
        2: op = OP_MUL;
        3: op = OP_DIV;
        4: op = OP_SLT;
        5: op = OP_AND;
        6: op = 4'b1111;
        default: op = 4'b0100;
      endcase
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) rb = 64'($urandom_range(0, 20));
      run_op(op, ra, rb, 1'($urandom), TAG_W'($urandom), $urandom_range(0, 3), 0,
             res, tg, er, zr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequencing controller in front of the 64-bit integer ALU (CLA adder, subtractor, array multiplier, divider). Accepts one operation at a time over a valid/ready request port and drives registered operands and the 4-bit ALUCtrl code into the ALU. Holds them stable for an op-dependent number of cycles so multi-cycle multiply/divide paths settle, then captures the result. Returns it over a valid/ready response port with a tag and error flag.

## Interface
- MUL_LAT, 4, cycles ALU operands are held for multiply (0011); must be >= 1
- DIV_LAT, 8, cycles held for divide (0001); must be >= 1
- TAG_W, 4, width of request/response tag
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous abort of the in-flight op
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_op  in  4  ALUCtrl code: 0010 ADD, 0110 SUB, 0011 MUL, 0001 DIV, 0111 SLT, 0000 AND
- req_a, req_b  in  64  signed operands
- req_cin  in  1  carry-in (ADD only)
- req_tag  in  TAG_W  returned unchanged on the response
- alu_a, alu_b  out  64  registered operands to ALU
- alu_cin  out  1  registered carry-in
- alu_ctrl  out  4  registered ALUCtrl
- alu_result  in  128  ALU Result
- alu_zero, alu_overflow  in  1  ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts
- rsp_result  out  128  captured result
- rsp_zero, rsp_overflow, rsp_err  out  1  captured flags
- rsp_tag  out  TAG_W  tag of the op
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, DONE.
- req_ready = !flush && (IDLE || (DONE && rsp_ready)). The combinational path rsp_ready -> req_ready is intentional.
- Accept (req_valid && req_ready at an edge):
  - Register op/a/b/cin/tag into alu_* and the tag register.
  - Load cnt = LAT-1, where LAT = MUL_LAT for 0011, DIV_LAT for 0001, else 1.
  - Go to EXEC.
- DIV with req_b == 0, or any op code not in the list above:
  - LAT forced to 1 and err latched.
  - alu_ctrl still driven with the code.
- EXEC, each edge:
  - If cnt == 0: capture into rsp_*, go to DONE.
  - Else: decrement cnt. alu_* remain stable throughout EXEC.
- Capture rules:
  - rsp_result = err ? 0 : alu_result.
  - rsp_zero = err ? 1 : alu_zero.
  - rsp_overflow = alu_overflow only for ADD/SUB without err, else 0. ALU overflow is undefined for other ops and is masked.
  - rsp_err = err.
- DONE: rsp_valid = 1 and rsp_* held stable until rsp_ready.
  - On the rsp_ready edge: go to EXEC if a new request is accepted on the same edge, otherwise IDLE.
- flush (any state, highest priority): next state IDLE, rsp_valid = 0, no response for the aborted op, no accept that cycle. alu_* keep their last values.

## Timing
- Reset (async assert, any time, including mid-EXEC):
  - State IDLE, cnt = 0.
  - All registered outputs 0: alu_a, alu_b, alu_cin, alu_ctrl (0000), rsp_result, rsp_zero, rsp_overflow, rsp_err, rsp_tag.
  - rsp_valid = 0, busy = 0, req_ready = 1 (given flush = 0).
- Accept at edge E0 -> alu_* valid after E0 -> capture at edge E(LAT) -> rsp_valid high after E(LAT).
- Response retire at the first edge with rsp_ready = 1, earliest E(LAT+1).
- With rsp_ready held high, back-to-back ops: one per LAT+1 cycles (ADD: one per 2 cycles).
- busy = 1 from after E0 until the retire edge that does not accept a new op.
- rsp_valid never drops without rsp_ready except on flush or reset.
- rsp_* never change while rsp_valid && !rsp_ready.

## Test plan
- Reset mid-EXEC of a MUL, then release -> all outputs 0 and req_ready = 1 immediately; no rsp_valid ever for that op.
- ADD a = 5, b = 7, cin = 1, tag = 3, rsp_ready = 1 -> rsp_valid exactly 1 cycle after accept; rsp_result = 13, rsp_tag = 3, zero = 0, err = 0. Back-to-back ADDs are accepted every 2 cycles.
- MUL a = -3, b = 4 with MUL_LAT = 4 -> alu_* stable for 4 cycles; rsp_result = -12 (128-bit sign-extended) 4 cycles after accept; rsp_overflow = 0 even if alu_overflow = 1.
- DIV a = 100, b = 0 -> response 1 cycle after accept; rsp_err = 1, rsp_result = 0, rsp_zero = 1. DIV a = 100, b = 7 -> result 14 after DIV_LAT cycles.
- SUB with rsp_ready low for 5 cycles, random req_valid -> rsp_* stable, req_ready = 0 throughout. On raising rsp_ready with req_valid = 1 -> retire and accept on the same edge.
- flush asserted 2 cycles into a DIV (DIV_LAT = 8) with req_valid = 1 -> no response, no accept during flush; the next request is accepted the cycle after flush drops and completes normally.
